// File: rtl/stopwatch_core.sv
// MM:SS stopwatch (00:00..99:59) with run/pause, field adjust and blink,
// driving four registered active-low 7-segment cathode patterns.
module stopwatch_core #(
  parameter int unsigned MIN_MAX = 99,
  parameter int unsigned SEC_MAX = 59,
  parameter logic [6:0]  BLANK   = 7'b1111111
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       tick_blink,
  input  logic       pause_p,
  input  logic       adj,
  input  logic       sel,
  output logic [6:0] c_0,
  output logic [6:0] c_1,
  output logic [6:0] c_2,
  output logic [6:0] c_3,
  output logic       running
);

  localparam logic [3:0] MinTMax = 4'(MIN_MAX / 10);
  localparam logic [3:0] MinOMax = 4'(MIN_MAX % 10);
  localparam logic [3:0] SecTMax = 4'(SEC_MAX / 10);
  localparam logic [3:0] SecOMax = 4'(SEC_MAX % 10);

  typedef enum logic [0:0] {StRun, StPaused} state_e;

  state_e     r_state, w_state_next;
  logic [3:0] r_min_t, r_min_o, r_sec_t, r_sec_o;
  logic [3:0] w_min_t, w_min_o, w_sec_t, w_sec_o;
  logic [7:0] w_min_inc, w_sec_inc;
  logic       r_blink_ph;
  logic       w_count, w_adj_inc, w_sec_wrap, w_blank_min, w_blank_sec;

  // Two-digit BCD increment that wraps to 00 after {tmax,omax}.
  function automatic logic [7:0] inc_field(input logic [3:0] t, input logic [3:0] o,
                                           input logic [3:0] tmax, input logic [3:0] omax);
    if (t == tmax && o == omax) return 8'h00;
    else if (o == 4'd9)         return {t + 4'd1, 4'd0};
    else                        return {t, o + 4'd1};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return BLANK;
    endcase
  endfunction

  // Run/pause state register.
  always_ff @(posedge clk_sys) begin
    if (!rst) r_state <= StRun;
    else      r_state <= w_state_next;
  end

  // Next-state: pause pulse toggles regardless of adjust mode.
  always_comb begin
    w_state_next = r_state;
    if (pause_p) w_state_next = (r_state == StRun) ? StPaused : StRun;
  end

  assign running = (r_state == StRun);

  // Next digit values: counting uses the pre-toggle state; adjust has no inter-field carry.
  always_comb begin
    w_sec_inc  = inc_field(r_sec_t, r_sec_o, SecTMax, SecOMax);
    w_min_inc  = inc_field(r_min_t, r_min_o, MinTMax, MinOMax);
    w_sec_wrap = (r_sec_t == SecTMax) && (r_sec_o == SecOMax);
    w_count    = tick_1hz && !adj && (r_state == StRun);
    w_adj_inc  = tick_2hz && adj;
    w_min_t    = r_min_t;
    w_min_o    = r_min_o;
    w_sec_t    = r_sec_t;
    w_sec_o    = r_sec_o;
    if (w_count) begin
      {w_sec_t, w_sec_o} = w_sec_inc;
      if (w_sec_wrap) {w_min_t, w_min_o} = w_min_inc;
    end else if (w_adj_inc) begin
      if (sel) {w_sec_t, w_sec_o} = w_sec_inc;
      else     {w_min_t, w_min_o} = w_min_inc;
    end
  end

  // Digit registers and blink phase (held at 0 outside adjust mode).
  always_ff @(posedge clk_sys) begin
    if (!rst) begin
      r_min_t    <= 4'd0;
      r_min_o    <= 4'd0;
      r_sec_t    <= 4'd0;
      r_sec_o    <= 4'd0;
      r_blink_ph <= 1'b0;
    end else begin
      r_min_t <= w_min_t;
      r_min_o <= w_min_o;
      r_sec_t <= w_sec_t;
      r_sec_o <= w_sec_o;
      if (!adj)            r_blink_ph <= 1'b0;
      else if (tick_blink) r_blink_ph <= ~r_blink_ph;
    end
  end

  assign w_blank_min = adj && r_blink_ph && !sel;
  assign w_blank_sec = adj && r_blink_ph && sel;

  // Registered cathode outputs, one cycle behind the digit registers.
  always_ff @(posedge clk_sys) begin
    if (!rst) begin
      c_0 <= 7'b0000001;
      c_1 <= 7'b0000001;
      c_2 <= 7'b0000001;
      c_3 <= 7'b0000001;
    end else begin
      c_0 <= w_blank_min ? BLANK : seg7(r_min_t);
      c_1 <= w_blank_min ? BLANK : seg7(r_min_o);
      c_2 <= w_blank_sec ? BLANK : seg7(r_sec_t);
      c_3 <= w_blank_sec ? BLANK : seg7(r_sec_o);
    end
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed self-checking bench for stopwatch_core.
module tb_stopwatch_core;

  logic       clk_sys = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0, tick_2hz = 1'b0, tick_blink = 1'b0, pause_p = 1'b0;
  logic       adj = 1'b0, sel = 1'b0;
  logic [6:0] c_0, c_1, c_2, c_3;
  logic       running;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100;
  localparam logic [6:0] S7 = 7'b0001111, S8 = 7'b0000000, S9 = 7'b0000100;
  localparam logic [6:0] SB = 7'b1111111;

  always #5 clk_sys = ~clk_sys;

  stopwatch_core dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .tick_1hz  (tick_1hz),
    .tick_2hz  (tick_2hz),
    .tick_blink(tick_blink),
    .pause_p   (pause_p),
    .adj       (adj),
    .sel       (sel),
    .c_0       (c_0),
    .c_1       (c_1),
    .c_2       (c_2),
    .c_3       (c_3),
    .running   (running)
  );

  // One-cycle strobe set: inputs change on negedge, sampled by the following posedge.
  task automatic cyc(input logic t1, input logic t2, input logic tb, input logic pp);
    @(negedge clk_sys);
    tick_1hz = t1; tick_2hz = t2; tick_blink = tb; pause_p = pp;
    @(negedge clk_sys);
    tick_1hz = 1'b0; tick_2hz = 1'b0; tick_blink = 1'b0; pause_p = 1'b0;
  endtask

  // Let the registered cathodes catch up with the digit registers.
  task automatic settle();
    @(negedge clk_sys);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    rst = 1'b0; adj = 1'b0; sel = 1'b0;
    @(negedge clk_sys);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({c_0, c_1, c_2, c_3} !== {S0, S0, S0, S0}) begin
      bad++; $display("FAIL reset_digits: got %b want %b", {c_0, c_1, c_2, c_3}, {S0, S0, S0, S0});
    end
    total++;
    if (running !== 1'b1) begin
      bad++; $display("FAIL reset_running: got %b want 1", running);
    end
  endtask

  task automatic test_count();
    for (int i = 0; i < 75; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    total++;
    if ({c_0, c_1, c_2, c_3} !== {S0, S1, S1, S5}) begin
      bad++; $display("FAIL count_0115: got %b want %b", {c_0, c_1, c_2, c_3}, {S0, S1, S1, S5});
    end
    total++;
    if (running !== 1'b1) begin
      bad++; $display("FAIL count_running: got %b want 1", running);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk_sys); adj = 1'b1; sel = 1'b0;
    for (int i = 0; i < 99; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk_sys); sel = 1'b1;
    for (int i = 0; i < 59; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    total++;
    if ({c_0, c_1, c_2, c_3} !== {S9, S9, S5, S9}) begin
      bad++; $display("FAIL preload_9959: got %b want %b", {c_0, c_1, c_2, c_3}, {S9, S9, S5, S9});
    end
    @(negedge clk_sys); adj = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    total++;
    if ({c_0, c_1, c_2, c_3} !== {S0, S0, S0, S0}) begin
      bad++; $display("FAIL wrap_0000: got %b want %b", {c_0, c_1, c_2, c_3}, {S0, S0, S0, S0});
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    total++;
    if ({c_0, c_1, c_2, c_3} !== {S0, S0, S0, S0}) begin
      bad++; $display("FAIL paused_hold: got %b want %b", {c_0, c_1, c_2, c_3}, {S0, S0, S0, S0});
    end
    total++;
    if (running !== 1'b0) begin
      bad++; $display("FAIL paused_running: got %b want 0", running);
    end
  endtask

  task automatic test_adjust();
    logic [13:0] exp_sec [3];
    exp_sec[0] = {S5, S9};
    exp_sec[1] = {S0, S0};
    exp_sec[2] = {S0, S1};
    cyc(1'b0, 1'b0, 1'b0, 1'b1);  // back to RUN so concurrent tick_1hz would count if not masked
    @(negedge clk_sys); adj = 1'b1; sel = 1'b1;
    for (int i = 0; i < 58; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      settle();
      total++;
      if ({c_0, c_1, c_2, c_3} !== {S0, S0, exp_sec[k]}) begin
        bad++;
        $display("FAIL adjust_sec_%0d: got %b want %b", k, {c_0, c_1, c_2, c_3}, {S0, S0, exp_sec[k]});
      end
    end
    total++;
    if (running !== 1'b1) begin
      bad++; $display("FAIL adjust_running: got %b want 1", running);
    end
  endtask

  task automatic test_blink();
    // Starts at 00:01, adj=1; preload minutes to 03.
    @(negedge clk_sys); sel = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    total++;
    if ({c_0, c_1, c_2, c_3} !== {SB, SB, S0, S1}) begin
      bad++; $display("FAIL blink_on: got %b want %b", {c_0, c_1, c_2, c_3}, {SB, SB, S0, S1});
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    total++;
    if ({c_0, c_1, c_2, c_3} !== {S0, S3, S0, S1}) begin
      bad++; $display("FAIL blink_off: got %b want %b", {c_0, c_1, c_2, c_3}, {S0, S3, S0, S1});
    end
    // Phase back to 1, then leaving adjust must clear it.
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk_sys); adj = 1'b0;
    settle();
    total++;
    if ({c_0, c_1, c_2, c_3} !== {S0, S3, S0, S1}) begin
      bad++; $display("FAIL blink_adj0: got %b want %b", {c_0, c_1, c_2, c_3}, {S0, S3, S0, S1});
    end
    @(negedge clk_sys); adj = 1'b1;
    settle(); settle();
    total++;
    if ({c_0, c_1, c_2, c_3} !== {S0, S3, S0, S1}) begin
      bad++; $display("FAIL blink_cleared: got %b want %b", {c_0, c_1, c_2, c_3}, {S0, S3, S0, S1});
    end
    @(negedge clk_sys); adj = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    total++;
    if ({c_0, c_1, c_2, c_3} !== {S0, S0, S0, S8}) begin
      bad++; $display("FAIL tick_pause_0008: got %b want %b", {c_0, c_1, c_2, c_3}, {S0, S0, S0, S8});
    end
    total++;
    if (running !== 1'b0) begin
      bad++; $display("FAIL tick_pause_running: got %b want 0", running);
    end
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk_sys); adj = 1'b1; tick_1hz = 1'b1;
    @(negedge clk_sys); tick_1hz = 1'b0;
    settle();
    total++;
    if ({c_0, c_1, c_2, c_3} !== {S0, S0, S0, S7}) begin
      bad++; $display("FAIL adj_rise_0007: got %b want %b", {c_0, c_1, c_2, c_3}, {S0, S0, S0, S7});
    end
    // Both ticks in count mode: only the 1 Hz strobe acts (no minute bump).
    @(negedge clk_sys); adj = 1'b0; sel = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    total++;
    if ({c_0, c_1, c_2, c_3} !== {S0, S0, S0, S8}) begin
      bad++; $display("FAIL both_ticks_0008: got %b want %b", {c_0, c_1, c_2, c_3}, {S0, S0, S0, S8});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk_sys); adj = 1'b1; sel = 1'b0;
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk_sys); sel = 1'b1;
    for (int i = 0; i < 34; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk_sys); adj = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);  // pause so the reset visibly restores RUN
    settle();
    total++;
    if ({c_0, c_1, c_2, c_3} !== {S1, S2, S3, S4} || running !== 1'b0) begin
      bad++;
      $display("FAIL pre_reset_1234: got %b run=%b want %b run=0", {c_0, c_1, c_2, c_3}, running,
               {S1, S2, S3, S4});
    end
    @(negedge clk_sys); rst = 1'b0; tick_1hz = 1'b1;
    @(negedge clk_sys); rst = 1'b1; tick_1hz = 1'b0;
    total++;
    if (running !== 1'b1) begin
      bad++; $display("FAIL mid_reset_running: got %b want 1", running);
    end
    settle();
    total++;
    if ({c_0, c_1, c_2, c_3} !== {S0, S0, S0, S0}) begin
      bad++; $display("FAIL mid_reset_digits: got %b want %b", {c_0, c_1, c_2, c_3}, {S0, S0, S0, S0});
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_adjust();
    test_blink();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
